// File: rtl/map_tile_arbiter_if.sv
// Bus bundle for map_tile_arbiter: player requests, level control, ROM and map RAM ports.
interface map_tile_arbiter_if #(
  parameter int unsigned TILE_W = 3
);
  logic              req1;
  logic              req2;
  logic [8:0]        idx1;
  logic [8:0]        idx2;
  logic              ack1;
  logic              ack2;
  logic              win;
  logic              next_level;
  logic [1:0]        rom_level;
  logic [8:0]        rom_cell;
  logic [TILE_W-1:0] rom_data;
  logic [8:0]        ram_addr;
  logic              ram_we;
  logic [TILE_W-1:0] ram_wdata;
  logic [TILE_W-1:0] ram_rdata;
  logic [1:0]        level;
  logic              busy;

  // Arbiter side
  modport slave (
    input  req1, req2, idx1, idx2, win, next_level, rom_data, ram_rdata,
    output ack1, ack2, rom_level, rom_cell, ram_addr, ram_we, ram_wdata, level, busy
  );

  // Player / storage side
  modport master (
    output req1, req2, idx1, idx2, win, next_level, rom_data, ram_rdata,
    input  ack1, ack2, rom_level, rom_cell, ram_addr, ram_we, ram_wdata, level, busy
  );
endinterface

// File: rtl/map_tile_arbiter.sv
// Sequencer/arbiter owning all writes to the 20x15 tile map RAM: level load from ROM,
// playfield clear on win, and round-robin read-modify-write tile toggles for two players.
// Optional macro MAP_TILE_BUILD_EN: empty tiles toggle to wall (players can build).
module map_tile_arbiter #(
  parameter int unsigned MAP_W      = 20,
  parameter int unsigned MAP_H      = 15,
  parameter int unsigned MAP_CELLS  = 300,
  parameter int unsigned NUM_LEVELS = 3,
  parameter int unsigned TILE_W     = 3
) (
  input logic               Clk,
  input logic               Reset,
  map_tile_arbiter_if.slave bus
);

  localparam logic [2:0] StLoad  = 3'd0;
  localparam logic [2:0] StClear = 3'd1;
  localparam logic [2:0] StIdle  = 3'd2;
  localparam logic [2:0] StRd    = 3'd3;
  localparam logic [2:0] StMod   = 3'd4;

  localparam logic [8:0] CellCount    = 9'(MAP_CELLS);
  localparam logic [8:0] LastCell     = 9'(MAP_CELLS - 1);
  localparam logic [8:0] LastRowStart = 9'((MAP_H - 1) * MAP_W);
  localparam logic [8:0] RowLen       = 9'(MAP_W);
  localparam logic [4:0] LastCol      = 5'(MAP_W - 1);
  localparam logic [1:0] LastLevel    = 2'(NUM_LEVELS - 1);

  localparam logic [TILE_W-1:0] TileEmpty  = TILE_W'(0);
  localparam logic [TILE_W-1:0] TileBorder = TILE_W'(1);
  localparam logic [TILE_W-1:0] TileWall   = TILE_W'(2);
  localparam logic [TILE_W-1:0] TileSoft   = TILE_W'(6);

  logic [2:0]        state_q, state_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [4:0]        col_q, col_d;
  logic [1:0]        level_q, level_d;
  logic              pend_win_q, pend_win_d;
  logic              pend_nl_q, pend_nl_d;
  logic              last_q, last_d;   // last granted player: 0 = player 1, 1 = player 2
  logic              gnt_q, gnt_d;
  logic [8:0]        idx_q, idx_d;
  logic [TILE_W-1:0] tile_new;
  logic              is_edge;

  // State and counter registers with synchronous reset into a level-0 load
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= StLoad;
      cnt_q      <= '0;
      col_q      <= '0;
      level_q    <= '0;
      pend_win_q <= 1'b0;
      pend_nl_q  <= 1'b0;
      last_q     <= 1'b1;
      gnt_q      <= 1'b0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      col_q      <= col_d;
      level_q    <= level_d;
      pend_win_q <= pend_win_d;
      pend_nl_q  <= pend_nl_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      idx_q      <= idx_d;
    end
  end

  // Next-state: sequencing, pending-event service and round-robin grant
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    col_d      = col_q;
    level_d    = level_q;
    pend_win_d = pend_win_q | bus.win;
    pend_nl_d  = pend_nl_q | bus.next_level;
    last_d     = last_q;
    gnt_d      = gnt_q;
    idx_d      = idx_q;
    case (state_q)
      StLoad: begin
        // One extra cycle past the last address drains the ROM pipeline
        if (cnt_q == CellCount) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      StClear: begin
        col_d = (col_q == LastCol) ? 5'd0 : col_q + 5'd1;
        if (cnt_q == LastCell) begin
          state_d = StIdle;
          cnt_d   = '0;
          col_d   = '0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      StIdle: begin
        if (pend_win_q) begin
          state_d    = StClear;
          cnt_d      = '0;
          col_d      = '0;
          pend_win_d = bus.win;
        end else if (pend_nl_q) begin
          state_d   = StLoad;
          cnt_d     = '0;
          level_d   = (level_q == LastLevel) ? 2'd0 : level_q + 2'd1;
          pend_nl_d = bus.next_level;
        end else if (bus.req1 || bus.req2) begin
          // On a tie, grant the player not served last
          gnt_d   = (bus.req1 && bus.req2) ? ~last_q : bus.req2;
          last_d  = gnt_d;
          idx_d   = gnt_d ? bus.idx2 : bus.idx1;
          state_d = StRd;
        end
      end
      StRd:    state_d = StMod;
      StMod:   state_d = StIdle;
      default: begin
        state_d = StLoad;
        cnt_d   = '0;
      end
    endcase
  end

  // Toggle rule applied to the tile read back in MOD
  always_comb begin
    tile_new = bus.ram_rdata;
    if (bus.ram_rdata == TileWall || bus.ram_rdata == TileSoft) begin
      tile_new = TileEmpty;
    end
`ifdef MAP_TILE_BUILD_EN
    else if (bus.ram_rdata == TileEmpty) begin
      tile_new = TileWall;
    end
`endif
  end

  // Output decode from state; write data is forced to 0 whenever no write occurs
  always_comb begin
    is_edge       = (cnt_q < RowLen) || (cnt_q >= LastRowStart) ||
                    (col_q == 5'd0) || (col_q == LastCol);
    bus.rom_level = level_q;
    bus.rom_cell  = '0;
    bus.ram_addr  = '0;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = '0;
    bus.ack1      = 1'b0;
    bus.ack2      = 1'b0;
    bus.level     = level_q;
    bus.busy      = (state_q != StIdle);
    case (state_q)
      StLoad: begin
        bus.rom_cell = cnt_q;
        if (cnt_q != 9'd0) begin
          bus.ram_we    = 1'b1;
          bus.ram_addr  = cnt_q - 9'd1;
          bus.ram_wdata = bus.rom_data;
        end
      end
      StClear: begin
        bus.ram_we    = 1'b1;
        bus.ram_addr  = cnt_q;
        bus.ram_wdata = is_edge ? TileBorder : TileEmpty;
      end
      StRd: bus.ram_addr = idx_q;
      StMod: begin
        bus.ram_addr = idx_q;
        if (idx_q < CellCount && tile_new != bus.ram_rdata) begin
          bus.ram_we    = 1'b1;
          bus.ram_wdata = tile_new;
        end
        bus.ack1 = ~gnt_q;
        bus.ack2 = gnt_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_map_tile_arbiter.sv
// Scoreboard bench for map_tile_arbiter: ROM/RAM models, transaction-level map model,
// expected writes/acks queued at stimulus time and checked by an independent monitor.
module tb_map_tile_arbiter;
  localparam int Cells = 300;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  map_tile_arbiter_if #(.TILE_W(3)) bus ();

  map_tile_arbiter #(
    .MAP_W(20), .MAP_H(15), .MAP_CELLS(300), .NUM_LEVELS(3), .TILE_W(3)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  int nchecks = 0;
  int nfail = 0;
  logic [11:0] wq[$];     // expected writes {addr, data}
  logic [1:0]  aq[$];     // expected acks {ack2, ack1}
  logic [2:0]  model[Cells];
  logic [2:0]  ram[Cells];
  int last_p;
  int lvl_m;
  logic [11:0] wexp;
  logic [1:0]  aexp;

  function automatic bit edge_cell(int c);
    int row, col;
    row = c / 20;
    col = c % 20;
    return row == 0 || row == 14 || col == 0 || col == 19;
  endfunction

  function automatic int rom_fn(int lv, int c);
    if (edge_cell(c)) return 1;
    if (lv == 0 && c == 25) return 2;
    if (lv == 0 && c == 21) return 0;
    return (c * 7 + lv * 5 + c / 20) % 7;
  endfunction

  function automatic logic [2:0] toggle(logic [2:0] t);
    if (t == 3'd2 || t == 3'd6) return 3'd0;
`ifdef MAP_TILE_BUILD_EN
    if (t == 3'd0) return 3'd2;
`endif
    return t;
  endfunction

  // ROM and single-port RAM, both with one-cycle read latency
  always @(posedge Clk) begin
    if (bus.ram_we && int'(bus.ram_addr) < Cells) ram[int'(bus.ram_addr)] <= bus.ram_wdata;
    bus.ram_rdata <= (int'(bus.ram_addr) < Cells) ? ram[int'(bus.ram_addr)] : 3'd0;
    bus.rom_data  <= 3'(rom_fn(int'(bus.rom_level), int'(bus.rom_cell)));
  end

  task automatic check(input string name, input int got, input int exp);
    nchecks++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Monitor: every write and ack the DUT presents must match the head of its queue
  always @(negedge Clk) begin
    if (!Reset) begin
      if (bus.ram_we) begin
        if (wq.size() == 0) begin
          nchecks++;
          nfail++;
          $display("FAIL unexpected_write: addr=%0d data=%0d, none expected",
                   bus.ram_addr, bus.ram_wdata);
        end else begin
          wexp = wq.pop_front();
          check("ram_write{addr,data}", int'({bus.ram_addr, bus.ram_wdata}), int'(wexp));
        end
      end
      if (bus.ack1 || bus.ack2) begin
        if (aq.size() == 0) begin
          nchecks++;
          nfail++;
          $display("FAIL unexpected_ack: ack1=%0d ack2=%0d, none expected", bus.ack1, bus.ack2);
        end else begin
          aexp = aq.pop_front();
          check("ack{2,1}", int'({bus.ack2, bus.ack1}), int'(aexp));
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic push_load(input int lv);
    for (int i = 0; i < Cells; i++) begin
      wq.push_back({9'(i), 3'(rom_fn(lv, i))});
      model[i] = 3'(rom_fn(lv, i));
    end
  endtask

  task automatic push_clear();
    for (int i = 0; i < Cells; i++) begin
      model[i] = edge_cell(i) ? 3'd1 : 3'd0;
      wq.push_back({9'(i), model[i]});
    end
  endtask

  task automatic predict(input int p, input int idx);
    logic [2:0] nw;
    aq.push_back(p == 1 ? 2'b01 : 2'b10);
    if (idx < Cells) begin
      nw = toggle(model[idx]);
      if (nw != model[idx]) begin
        wq.push_back({9'(idx), nw});
        model[idx] = nw;
      end
    end
    last_p = p;
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((wq.size() != 0 || bus.busy) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) begin
      nchecks++;
      nfail++;
      $display("FAIL idle_wait: busy=%0d pending_writes=%0d after %0d cycles",
               bus.busy, wq.size(), n);
    end
  endtask

  task automatic count_busy(input string name, input int exp);
    int n = 0;
    while (bus.busy && n < 2000) begin
      n++;
      tick();
    end
    check(name, n, exp);
  endtask

  // One request transaction; optionally pulses win+next_level while the RMW is in flight
  task automatic do_req(input bit r1, input bit r2, input int i1, input int i2, input bit inject);
    int first, lat1, lat2, e1, e2;
    wait_quiet();
    first = (r1 && r2) ? ((last_p == 2) ? 1 : 2) : (r1 ? 1 : 2);
    e1 = (first == 1) ? 2 : 5;
    e2 = (first == 2) ? 2 : 5;
    if (r1 && r2) begin
      if (first == 1) begin predict(1, i1); predict(2, i2); end
      else begin predict(2, i2); predict(1, i1); end
    end else if (r1) predict(1, i1);
    else predict(2, i2);
    if (inject) begin
      push_clear();
      lvl_m = (lvl_m + 1) % 3;
      push_load(lvl_m);
    end
    bus.idx1 = 9'(i1);
    bus.idx2 = 9'(i2);
    bus.req1 = r1;
    bus.req2 = r2;
    lat1 = -1;
    lat2 = -1;
    for (int k = 1; k <= 12 && (bus.req1 || bus.req2); k++) begin
      @(negedge Clk);
      if (inject && k == 1) begin bus.win = 1'b1; bus.next_level = 1'b1; end
      if (inject && k == 2) begin bus.win = 1'b0; bus.next_level = 1'b0; end
      if (bus.ack1) begin lat1 = k - 1; bus.req1 = 1'b0; end
      if (bus.ack2) begin lat2 = k - 1; bus.req2 = 1'b0; end
    end
    bus.win = 1'b0;
    bus.next_level = 1'b0;
    bus.req1 = 1'b0;
    bus.req2 = 1'b0;
    if (r1) check("ack1_latency", lat1, e1);
    if (r2) check("ack2_latency", lat2, e2);
  endtask

  task automatic check_ram();
    int bad = 0;
    for (int i = 0; i < Cells; i++) if (ram[i] != model[i]) bad++;
    check("ram_cells_differing_from_model", bad, 0);
  endtask

  task automatic rand_reqs(input int n);
    for (int t = 0; t < n; t++) begin
      int r, a, b;
      r = $urandom_range(1, 3);
      a = ($urandom_range(0, 9) == 0) ? $urandom_range(300, 511) : $urandom_range(0, 299);
      b = ($urandom_range(0, 9) == 0) ? $urandom_range(300, 511) : $urandom_range(0, 299);
      do_req(r[0], r[1], a, b, 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req1 = 1'b0;
    bus.req2 = 1'b0;
    bus.idx1 = '0;
    bus.idx2 = '0;
    bus.win = 1'b0;
    bus.next_level = 1'b0;
    for (int i = 0; i < Cells; i++) begin
      model[i] = '0;
      ram[i] = '0;
    end
    last_p = 2;
    lvl_m = 0;

    Reset = 1'b1;
    repeat (3) tick();
    check("reset_ack1", bus.ack1, 0);
    check("reset_ack2", bus.ack2, 0);
    check("reset_ram_we", bus.ram_we, 0);
    check("reset_ram_addr", bus.ram_addr, 0);
    check("reset_ram_wdata", bus.ram_wdata, 0);
    check("reset_rom_cell", bus.rom_cell, 0);
    check("reset_level", bus.level, 0);
    check("reset_busy", bus.busy, 1);
    push_load(0);
    Reset = 1'b0;
    count_busy("load_busy_cycles", 301);
    check("load_writes_outstanding", wq.size(), 0);
    check("level_after_load", bus.level, 0);
    check_ram();

    // Directed: tie from reset, destroy wall, build/no-build, border cell, out-of-range
    do_req(1'b1, 1'b1, 30, 40, 1'b0);
    do_req(1'b1, 1'b0, 25, 0, 1'b0);
    do_req(1'b0, 1'b1, 0, 21, 1'b0);
    do_req(1'b1, 1'b0, 0, 0, 1'b0);
    do_req(1'b0, 1'b1, 0, 305, 1'b0);

    rand_reqs(60);

    // win + next_level during a RMW: ack, CLEAR, then LOAD of level 1
    do_req(1'b1, 1'b0, $urandom_range(0, 299), 0, 1'b1);
    wait_quiet();
    check("level_after_win_next", bus.level, 1);
    check_ram();

    // Advance to level 2, then reset partway through its load
    bus.next_level = 1'b1;
    tick();
    bus.next_level = 1'b0;
    lvl_m = 2;
    push_load(2);
    repeat (50) tick();
    bus.idx1 = 9'd50;
    bus.req1 = 1'b1;
    repeat (70) tick();
    Reset = 1'b1;
    tick();
    check("midreset_level", bus.level, 0);
    check("midreset_rom_cell", bus.rom_cell, 0);
    check("midreset_busy", bus.busy, 1);
    check("midreset_ack1", bus.ack1, 0);
    wq.delete();
    lvl_m = 0;
    last_p = 2;
    push_load(0);
    bus.req1 = 1'b0;
    Reset = 1'b0;
    count_busy("reload_busy_cycles", 301);
    check("level_after_reload", bus.level, 0);
    check_ram();

    rand_reqs(20);
    wait_quiet();
    check("acks_outstanding", aq.size(), 0);
    check("writes_outstanding", wq.size(), 0);
    check_ram();

    $display("== %0d vectors applied, %0d miscompares ==", nchecks, nfail);
    $finish;
  end

endmodule

// File: doc/map_tile_arbiter.md
# map_tile_arbiter

Sequencer and arbiter for the shared 20x15 tile map RAM. Owns all writes to the map: loads a level image from the level ROM after reset or on level advance, clears the playfield on a win, and serializes tile-toggle requests from the two players into read-modify-write cycles on a single-port RAM. Sits between the player/bomb logic and the map storage read by the renderer.

## Interface
Parameters:
- MAP_W, 20, tiles per row
- MAP_H, 15, rows
- MAP_CELLS, 300, MAP_W*MAP_H
- NUM_LEVELS, 3, level images in ROM
- TILE_W, 3, bits per tile code

Ports (one clock `Clk`; `Reset` is synchronous, active-high):
- Clk  in  1  system clock
- Reset  in  1  synchronous active-high reset
- req1 / req2  in  1  player tile-change request, held until ack
- idx1 / idx2  in  9  target cell index, stable while req high
- ack1 / ack2  out  1  one-cycle completion pulse
- win  in  1  pulse: clear playfield
- next_level  in  1  pulse: advance level and reload
- rom_level  out  2  level select to ROM
- rom_cell  out  9  cell address to ROM
- rom_data  in  TILE_W  ROM tile, valid 1 cycle after address
- ram_addr  out  9  map RAM address
- ram_we  out  1  map RAM write enable
- ram_wdata  out  TILE_W  map RAM write data
- ram_rdata  in  TILE_W  map RAM read data, valid 1 cycle after address
- level  out  2  current level index
- busy  out  1  high whenever state is not IDLE

## Operation
- Tile codes: 0 empty, 1 border, 2 wall, 3/4 bases, 5 hard block, 6 soft block.
- States: LOAD, CLEAR, IDLE, RD, MOD.
- LOAD: cell counter c from 0 to 299; drive rom_cell=c, rom_level=level; one cycle later write rom_data to ram_addr=c-1 (pipelined, one cell per cycle). After final write at c=299 -> IDLE.
- CLEAR: counter 0..299, writes 1 to edge cells (row 0, row 14, col 0, col 19), 0 elsewhere; no reads. Then -> IDLE.
- win and next_level latch into pending flags in any state; cleared when serviced.
- IDLE priority: pending win -> CLEAR; else pending next_level -> level = (level+1) mod NUM_LEVELS, -> LOAD; else tile request.
- Arbitration: round-robin; pointer = last granted player. Both requesting -> grant the other one. Reset pointer so player 1 wins first tie.
- Tile request: IDLE latches idx of granted player -> RD (ram_addr=idx) -> MOD: evaluate ram_rdata, write new value if changed, pulse ack of granted player, -> IDLE.
- Toggle rule: 2 or 6 -> 0; 0 -> 2 (see Configuration); 1,3,4,5 unchanged (no write, ack still issued).
- idx >= 300: ack issued in MOD, no write, RAM not accessed meaningfully.
- Requests arriving during LOAD/CLEAR wait (no ack) until IDLE.

## Timing
- Reset values: ack1=ack2=0, ram_we=0, ram_addr=0, ram_wdata=0, rom_cell=0, level=0, pending flags=0, rr pointer=player 2, busy=1; state=LOAD (level 0 reload begins first cycle after Reset falls).
- LOAD: 301 cycles (300 writes + 1 pipeline fill). CLEAR: 300 cycles.
- Tile RMW: req sampled in IDLE cycle T, ack and ram_we in T+2, IDLE again T+3; back-to-back throughput one per 3 cycles.
- win and next_level pending simultaneously: CLEAR first, then LOAD of incremented level.
- next_level during LOAD: current load completes, then second load of the next level.
- Reset mid-operation: abort immediately, restart LOAD of level 0, pending requests discarded, no ack.
- ram_we never asserted outside LOAD, CLEAR, MOD.

## Configuration
- MAP_TILE_BUILD_EN defined: empty tile 0 toggles to 2 (players can build walls).
- Not defined: 0 is unchanged; requests only destroy (2/6 -> 0); ack timing identical.

## Test plan
- Reset then release -> busy=1 for 301 cycles, 300 ram_we pulses with RAM contents equal to ROM level 0, level=0, then busy=0.
- RAM cell 25 holds 2; req1 idx1=25 -> ack1 two cycles later, ram_we=1, ram_wdata=0 to address 25.
- req1 idx1=30, req2 idx2=40 same cycle from reset state -> player 1 served first (ack1 at T+2), player 2 next (ack2 at T+5).
- Cell 21 holds 0, req2 idx2=21 -> with MAP_TILE_BUILD_EN write 2; without, ack2 with no ram_we. Cell 0 (code 1) -> ack, no write; idx=305 -> ack, no write.
- win and next_level pulsed together during a RMW -> RMW acks, CLEAR (300 cycles, border=1, interior=0), then LOAD with level=1.
- Reset asserted mid-LOAD of level 2 -> level=0, LOAD restarts at cell 0, no ack pulses.
